// File: rtl/minimap_renderer_pkg.sv
// Shared minimap constants, colours and render FSM encoding.
// Used by the renderer, level loader and raytracer.
package minimap_renderer_pkg;

  localparam int GRID_W = 40;
  localparam int GRID_H = 30;
  localparam int CELL   = 4;

  localparam logic [2:0] COL_PLAYER = 3'b100;
  localparam logic [2:0] COL_LINE   = 3'b000;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_PAINT,
    S_DONE
  } state_t;

  function automatic logic last_cell(
    input logic [5:0] cx,
    input logic [4:0] cy
  );
    return (cx == 6'(GRID_W - 1)) &&
           (cy == 5'(GRID_H - 1));
  endfunction

endpackage

// File: rtl/minimap_renderer.sv
// Raster-scans the 40x30 grid RAM and paints each cell
// as a 4x4 pixel block with grid lines and player marker.
module minimap_renderer
  import minimap_renderer_pkg::*;
(
  input  logic       clock,
  input  logic       reset,
  input  logic       start,
  output logic       done,
  input  logic [5:0] player_x,
  input  logic [4:0] player_y,
  output logic [5:0] grid_x,
  output logic [4:0] grid_y,
  input  logic [2:0] grid_out,
  output logic [7:0] vga_x,
  output logic [6:0] vga_y,
  output logic [2:0] vga_colour,
  output logic       vga_write
);

  state_t     r_state;
  state_t     w_next;
  logic [5:0] r_cx;
  logic [4:0] r_cy;
  logic [1:0] r_px;
  logic [1:0] r_py;
  logic [5:0] r_plx;
  logic [4:0] r_ply;
  logic [2:0] r_colour;
  logic       w_cell_end;
  logic       w_last;
  logic       w_edge;
  logic       w_player;

  assign w_cell_end = (r_px == 2'd3) && (r_py == 2'd3);
  assign w_last     = last_cell(r_cx, r_cy);
  assign w_edge     = (r_px == 2'd3) || (r_py == 2'd3);
  assign w_player   = (r_cx == r_plx) && (r_cy == r_ply);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_next = S_READ;
      S_READ:  w_next = S_WAIT;
      S_WAIT:  w_next = S_PAINT;
      S_PAINT: begin
        if (w_cell_end)
          w_next = w_last ? S_DONE : S_READ;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_cx     <= '0;
      r_cy     <= '0;
      r_px     <= '0;
      r_py     <= '0;
      r_plx    <= '0;
      r_ply    <= '0;
      r_colour <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (start) begin
            r_plx <= player_x;
            r_ply <= player_y;
            r_cx  <= '0;
            r_cy  <= '0;
          end
        end
        S_WAIT: begin
          r_colour <= grid_out;
          r_px     <= '0;
          r_py     <= '0;
        end
        S_PAINT: begin
          r_px <= r_px + 2'd1;
          if (r_px == 2'd3)
            r_py <= r_py + 2'd1;
          // last cell keeps cx/cy; DONE follows
          if (w_cell_end && !w_last) begin
            if (r_cx == 6'(GRID_W - 1)) begin
              r_cx <= '0;
              r_cy <= r_cy + 5'd1;
            end else begin
              r_cx <= r_cx + 6'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    done       = 1'b0;
    vga_write  = 1'b0;
    vga_x      = '0;
    vga_y      = '0;
    vga_colour = COL_LINE;
    grid_x     = r_cx;
    grid_y     = r_cy;
    unique case (r_state)
      S_PAINT: begin
        vga_write = 1'b1;
        // CELL is 4, so 4*c+p is a plain concatenation
        vga_x     = {r_cx, r_px};
        vga_y     = {r_cy, r_py};
        if (w_edge)
          vga_colour = COL_LINE;
        else if (w_player)
          vga_colour = COL_PLAYER;
        else
          vga_colour = r_colour;
      end
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/minimap_renderer.md
MINIMAP_RENDERER -- requirements
Module: minimap_renderer

Interface
REQ-001 SHALL have ports: clock  in  1  sole clock, rising edge.
REQ-002 SHALL have ports: reset  in  1  asynchronous, active-high; one clock; reset is asynchronous and active-high.
REQ-003 SHALL have ports: start  in  1  begin-render request, sampled only in IDLE.
REQ-004 SHALL have ports: done  out  1  one-cycle completion pulse.
REQ-005 SHALL have ports: player_x  in  6  player cell column, latched on accepted start.
REQ-006 SHALL have ports: player_y  in  5  player cell row, latched on accepted start.
REQ-007 SHALL have ports: grid_x  out  6  grid RAM read column.
REQ-008 SHALL have ports: grid_y  out  5  grid RAM read row.
REQ-009 SHALL have ports: grid_out  in  3  grid RAM data; synchronous read, valid the cycle after the address.
REQ-010 SHALL have ports: vga_x  out  8  pixel column, 0..159.
REQ-011 SHALL have ports: vga_y  out  7  pixel row, 0..119.
REQ-012 SHALL have ports: vga_colour  out  3  pixel colour.
REQ-013 SHALL have ports: vga_write  out  1  pixel write strobe.
REQ-014 SHALL have constants: GRID_W=40, GRID_H=30, CELL=4, COL_PLAYER=3'b100, COL_LINE=3'b000.

Function
REQ-015 SHALL implement the states IDLE, READ, WAIT, PAINT and DONE.
REQ-016 IDLE: start=1 SHALL latch player_x/player_y, set cx=0, cy=0 and go to READ; start=0 SHALL stay in IDLE.
REQ-017 READ: SHALL drive grid_x=cx, grid_y=cy, then go to WAIT; grid_x/grid_y SHALL hold those values through WAIT.
REQ-018 WAIT: SHALL register colour_reg<=grid_out, clear px/py, then go to PAINT.
REQ-019 PAINT: SHALL last 16 cycles with vga_write=1.
  - vga_x=4*cx+px, vga_y=4*cy+py.
  - px increments every cycle; on px=3, px wraps to 0 and py increments.
REQ-020 PAINT colour priority: px==3 or py==3 -> COL_LINE; else (cx,cy)==latched player -> COL_PLAYER; else colour_reg.
REQ-021 PAINT exit at px=3, py=3:
  - cx<39: cx+1, go to READ.
  - cx=39, cy<29: cx=0, cy+1, go to READ.
  - cx=39, cy=29: go to DONE.
REQ-022 DONE: SHALL assert done=1 for exactly one cycle, then go to IDLE.
REQ-023 Scan order SHALL be raster: cx inner, cy outer; each cell costs exactly 18 cycles.
REQ-024 Latency: first READ is the cycle after start is sampled; done SHALL assert exactly 1200*18=21600 cycles after the first READ cycle.
REQ-025 start asserted outside IDLE, including in DONE, SHALL be ignored, with no restart or queueing.
REQ-026 player_x>=40 or player_y>=30 SHALL match no cell, so no player colour is drawn.
REQ-027 vga_write SHALL be 0 in every state except PAINT.
REQ-028 All outputs SHALL derive from registers only, with no combinational input-to-output path.
REQ-029 Counter widths: cx 6 bits, cy 5 bits, px/py 2 bits; vga_x/vga_y arithmetic SHALL be unsigned and never exceed 159/119.

Reset
REQ-030 reset=1 SHALL immediately force IDLE and zero all outputs: done, vga_write, vga_x, vga_y, vga_colour, grid_x, grid_y.
REQ-031 reset SHALL zero cx, cy, px, py, colour_reg and the latched player position.
REQ-032 Reset mid-render SHALL abort with no done pulse; after release, the block SHALL wait for a new start.

Structure
REQ-033 GRID_W, GRID_H, CELL, the colour constants and the state encoding SHALL live in the shared project package, also used by the level loader and raytracer.
REQ-034 The block SHALL be flat; no sub-module is required, and the grid RAM is external.

Verification
REQ-035 All-zero grid, player (0,0), start pulse -> 19200 writes; cell (0,0) interior pixels (0..2,0..2) = 100; cell (1,0) pixel (4,0) = 000; done exactly once, 21600 cycles after the first READ.
REQ-036 Grid cell (5,7)=3'b011, player (39,29) -> pixel (21,29)=011, pixel (23,29)=000 (line), pixel (157,117)=100; no vga_x>159 or vga_y>119 ever observed.
REQ-037 Model grid RAM with 1-cycle read latency, random contents -> each cell's interior matches the RAM value at (cx,cy); grid_x/grid_y are stable through READ and WAIT.
REQ-038 start held high for the whole render plus 5 cycles after done -> exactly one render until done; a second render starts only because start is still high in IDLE.
REQ-039 Assert reset at cycle 5000 of a render -> outputs zero asynchronously; no done pulse; fresh start renders again from cell (0,0).
REQ-040 player (45,3) -> no pixel uses colour 100 unless present in the grid data.
